serial_pow2_divider_ctrl: RTL and testbench

- Sequencer that performs signed division of an N-bit operand by 2^k with a single 1-bit arithmetic-right-shift stage, reusing it once per clock.
- Two modes: floor (pure arithmetic shift) and truncate-toward-zero (shift plus a correction cycle).
- Sits between an upstream producer and a downstream consumer, using valid/ready handshakes on both sides.
- Single-entry: one operation in flight at a time.

---
 rtl/serial_pow2_divider_ctrl.sv | 76 +++++++
 tb/tb_serial_pow2_divider_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_pow2_divider_ctrl.sv
// serial_pow2_divider_ctrl: signed divide by 2^k using one 1-bit arithmetic shift per clock.
module serial_pow2_divider_ctrl #(
   parameter int N  = 8,
   parameter int SW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_data,
   input  logic [SW-1:0] up_shift,
   input  logic          up_mode,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_data,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;
   state_t state, state_n;
   logic [N-1:0] data, data_n;
   logic [SW-1:0] count, count_n, k_eff;
   logic sticky, sticky_n, neg, neg_n, mode, mode_n;
   assign k_eff = (up_shift > SW'(N)) ? SW'(N) : up_shift;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         data   <= '0;
         count  <= '0;
         sticky <= 1'b0;
         neg    <= 1'b0;
         mode   <= 1'b0;
      end else begin
         state  <= state_n;
         data   <= data_n;
         count  <= count_n;
         sticky <= sticky_n;
         neg    <= neg_n;
         mode   <= mode_n;
      end
   end
   always_comb begin
      state_n  = state;
      data_n   = data;
      count_n  = count;
      sticky_n = sticky;
      neg_n    = neg;
      mode_n   = mode;
      case (state)
         IDLE: if (up_valid) begin
            data_n   = up_data;
            mode_n   = up_mode;
            neg_n    = up_data[N-1];
            sticky_n = 1'b0;
            count_n  = k_eff;
            state_n  = (k_eff != '0) ? SHIFT : (up_mode ? FIX : DONE);
         end
         SHIFT: begin
            sticky_n = sticky | data[0];
            data_n   = {data[N-1], data[N-1:1]};
            count_n  = count - 1'b1;
            state_n  = (count == SW'(1)) ? (mode ? FIX : DONE) : SHIFT;
         end
         // floor of a negative value with a nonzero remainder is one below trunc
         FIX: begin
            data_n  = data + {{(N-1){1'b0}}, neg & sticky};
            state_n = DONE;
         end
         DONE: state_n = down_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   assign up_ready   = (state == IDLE);
   assign down_valid = (state == DONE);
   assign busy       = (state != IDLE);
   assign down_data  = data;
endmodule

// File: tb/tb_serial_pow2_divider_ctrl.sv
// tb_serial_pow2_divider_ctrl: directed vectors checked against a cycle-count/arithmetic model.
module tb_serial_pow2_divider_ctrl;
   localparam int N  = 8;
   localparam int SW = $clog2(N) + 1;
   logic clk = 0, rst = 0;
   logic up_valid = 0, up_mode = 0, down_ready = 0;
   logic [N-1:0] up_data = '0;
   logic [SW-1:0] up_shift = '0;
   logic up_ready, down_valid, busy;
   logic [N-1:0] down_data;
   int n_tests = 0, n_fail = 0;
   bit chk = 0;
   bit m_busy = 0, m_valid = 0;
   int m_rem = 0;
   logic [N-1:0] m_res = '0;

   serial_pow2_divider_ctrl #(.N(N), .SW(SW)) dut (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
      .up_data(up_data), .up_shift(up_shift), .up_mode(up_mode),
      .down_valid(down_valid), .down_ready(down_ready),
      .down_data(down_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(string nm, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [N-1:0] ref_div(logic [N-1:0] a, int k, bit m);
      int ai = int'($signed(a));
      int ke = (k > N) ? N : k;
      int r = m ? ai / (1 << ke) : ai >>> ke;
      return r[N-1:0];
   endfunction

   // Model: result known at accept, valid after min(k,N)+mode edges, held until handshake.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_valid = 0; m_rem = 0;
      end else if (!m_busy) begin
         if (up_valid) begin
            m_busy  = 1;
            m_res   = ref_div(up_data, int'(up_shift), up_mode);
            m_rem   = ((int'(up_shift) > N) ? N : int'(up_shift)) + int'(up_mode);
            m_valid = (m_rem == 0);
         end
      end else if (m_valid) begin
         if (down_ready) begin
            m_busy = 0; m_valid = 0;
         end
      end else begin
         m_rem--;
         m_valid = (m_rem == 0);
      end
   end

   always @(negedge clk) begin
      if (chk && !rst) begin
         check("up_ready", int'(up_ready), int'(!m_busy));
         check("busy", int'(busy), int'(m_busy));
         check("down_valid", int'(down_valid), int'(m_valid));
         if (m_valid) check("down_data", int'(down_data), int'(m_res));
      end
   end

   task automatic start(logic [N-1:0] a, int k, bit m);
      up_data = a; up_shift = k[SW-1:0]; up_mode = m; up_valid = 1;
      @(posedge clk);
   endtask

   task automatic wait_result(string nm, logic [N-1:0] exp_d, int exp_lat, bit keep);
      int c = 0;
      @(negedge clk);
      if (!keep) up_valid = 0;
      while (!down_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      check({nm, " latency"}, c, exp_lat);
      check({nm, " data"}, int'(down_data), int'(exp_d));
   endtask

   task automatic handshake(int hold);
      repeat (hold) @(negedge clk);
      down_ready = 1;
      @(posedge clk);
      @(negedge clk);
      down_ready = 0;
   endtask

   task automatic op(string nm, logic [N-1:0] a, int k, bit m, logic [N-1:0] exp_d, int exp_lat);
      start(a, k, m);
      wait_result(nm, exp_d, exp_lat, 0);
      handshake(0);
   endtask

   initial begin
      #1 rst = 1;
      #2 check("reset up_ready", int'(up_ready), 1);
      check("reset busy", int'(busy), 0);
      check("reset down_valid", int'(down_valid), 0);
      check("reset down_data", int'(down_data), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      chk = 1;
      @(negedge clk);
      op("100/4", 8'd100, 2, 0, 8'h19, 2);
      op("-7 floor", 8'hF9, 1, 0, 8'hFC, 1);
      op("-7 trunc", 8'hF9, 1, 1, 8'hFD, 2);
      op("-128 trunc", 8'h80, 3, 1, 8'hF0, 4);
      op("-1 floor", 8'hFF, 3, 0, 8'hFF, 3);
      op("-1 trunc", 8'hFF, 3, 1, 8'h00, 4);
      op("k0", 8'h85, 0, 0, 8'h85, 0);
      op("k15 floor", 8'h80, 15, 0, 8'hFF, 8);
      op("k15 trunc", 8'h80, 15, 1, 8'h00, 9);
      op("k8 pos", 8'h7F, 8, 0, 8'h00, 8);
      op("-101 trunc", 8'h9B, 2, 1, 8'hE7, 3);
      op("-101 floor", 8'h9B, 2, 0, 8'hE6, 2);
      op("k0 trunc", 8'hF9, 0, 1, 8'hF9, 1);
      // backpressure with the next request already waiting upstream
      start(8'd100, 2, 0);
      @(negedge clk);
      up_data = 8'hF9; up_shift = 1; up_mode = 1;
      wait_result("bp", 8'h19, 1, 1);
      repeat (5) @(negedge clk);
      check("bp held data", int'(down_data), 8'h19);
      check("bp held valid", int'(down_valid), 1);
      check("bp up_ready", int'(up_ready), 0);
      down_ready = 1;
      @(posedge clk);
      @(negedge clk);
      down_ready = 0;
      check("bp idle gap", int'(up_ready), 1);
      @(posedge clk);
      wait_result("bp next", 8'hFD, 2, 0);
      handshake(2);
      // asynchronous reset in the middle of a shift sequence
      start(8'h55, 6, 0);
      @(negedge clk);
      up_valid = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1;
      #1 check("mid rst up_ready", int'(up_ready), 1);
      check("mid rst busy", int'(busy), 0);
      check("mid rst down_valid", int'(down_valid), 0);
      check("mid rst down_data", int'(down_data), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (10) @(negedge clk);
      check("no stale result", int'(down_valid), 0);
      op("post rst", 8'hF9, 1, 1, 8'hFD, 2);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
